// File: rtl/falling_piece_controller_pkg.sv
// Shared types and helpers for the falling-piece controller.
package falling_piece_controller_pkg;

  typedef enum logic [2:0] {
    BLANK,
    TILE_I,
    TILE_O,
    TILE_T,
    TILE_S,
    TILE_Z,
    TILE_J,
    TILE_L
  } tile_type_t;

  typedef enum logic [1:0] {
    ORIENTATION_0,
    ORIENTATION_R,
    ORIENTATION_2,
    ORIENTATION_L
  } orientation_t;

  typedef enum logic [1:0] {
    FC_IDLE,
    FC_FALLING,
    FC_LOCKING,
    FC_LOCKED
  } fc_state_t;

  localparam logic [4:0] DEFAULT_SPAWN_ROW = 5'd1;
  localparam logic [4:0] DEFAULT_SPAWN_COL = 5'd4;

  // Clockwise step: 0 -> R -> 2 -> L -> 0.
  function automatic orientation_t orient_cw(input orientation_t o);
    case (o)
      ORIENTATION_0: orient_cw = ORIENTATION_R;
      ORIENTATION_R: orient_cw = ORIENTATION_2;
      ORIENTATION_2: orient_cw = ORIENTATION_L;
      default:       orient_cw = ORIENTATION_0;
    endcase
  endfunction

  // Counter-clockwise step: 0 -> L -> 2 -> R -> 0.
  function automatic orientation_t orient_ccw(input orientation_t o);
    case (o)
      ORIENTATION_0: orient_ccw = ORIENTATION_L;
      ORIENTATION_L: orient_ccw = ORIENTATION_2;
      ORIENTATION_2: orient_ccw = ORIENTATION_R;
      default:       orient_ccw = ORIENTATION_0;
    endcase
  endfunction

endpackage

// File: rtl/falling_piece_controller_lock_delay_timer.sv
// Lock delay counter with a bounded number of restarts per piece.
module falling_piece_controller_lock_delay_timer #(
  parameter int LOCK_DELAY_CYCLES = 25_000_000,
  parameter int MAX_LOCK_RESETS   = 15
) (
  input  logic clk,
  input  logic rst_l,
  input  logic clear_all,   // new piece: counter and restart budget cleared
  input  logic restart,     // not resting: counter held at zero
  input  logic count_en,    // resting this cycle
  input  logic kick,        // successful move/rotate while resting
  output logic expired,
  output logic reset_avail
);

  localparam int CW = (LOCK_DELAY_CYCLES > 1) ? $clog2(LOCK_DELAY_CYCLES) : 1;
  localparam int RW = (MAX_LOCK_RESETS > 0) ? $clog2(MAX_LOCK_RESETS + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(LOCK_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_LOCK_RESETS);

  logic [CW-1:0] cnt_q;
  logic [RW-1:0] rc_q;

  assign expired     = (cnt_q == LAST);
  assign reset_avail = (rc_q < RMAX);

  // Counter saturates at LAST so an action on the final cycle just delays the lock by one.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q <= '0;
      rc_q  <= '0;
    end else if (clear_all) begin
      cnt_q <= '0;
      rc_q  <= '0;
    end else if (restart) begin
      cnt_q <= '0;
    end else if (count_en) begin
      if (kick && reset_avail) begin
        cnt_q <= '0;
        rc_q  <= rc_q + 1'b1;
      end else if (!expired) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/falling_piece_controller.sv
// Owns the falling tetromino: spawn, one action per cycle, gravity, lock delay, hard drop.
// Spawn handshake: a piece is taken on a rising clk edge where spawn_valid && spawn_ready;
// spawn_ready is high only in IDLE, and spawn_valid outside IDLE is simply ignored.
module falling_piece_controller
  import falling_piece_controller_pkg::*;
#(
  parameter logic [4:0] SPAWN_ROW         = DEFAULT_SPAWN_ROW,
  parameter logic [4:0] SPAWN_COL         = DEFAULT_SPAWN_COL,
  parameter int         LOCK_DELAY_CYCLES = 25_000_000,
  parameter int         MAX_LOCK_RESETS   = 15
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         spawn_valid,
  input  tile_type_t   spawn_type,
  output logic         spawn_ready,
  input  logic         gravity_tick,
  input  logic         in_rotate_R,
  input  logic         in_rotate_L,
  input  logic         in_move_R,
  input  logic         in_move_L,
  input  logic         in_soft_drop,
  input  logic         in_hard_drop,
  input  logic [4:0]   hard_drop_row,
  output logic [4:0]   rotate_R_row,
  output logic [4:0]   rotate_R_col,
  output logic [4:0]   rotate_L_row,
  output logic [4:0]   rotate_L_col,
  output logic [4:0]   move_R_row,
  output logic [4:0]   move_R_col,
  output logic [4:0]   move_L_row,
  output logic [4:0]   move_L_col,
  output logic [4:0]   soft_drop_row,
  output logic [4:0]   soft_drop_col,
  output orientation_t rotate_R_orientation,
  output orientation_t rotate_L_orientation,
  output orientation_t move_R_orientation,
  output orientation_t move_L_orientation,
  output orientation_t soft_drop_orientation,
  input  logic         rotate_R_valid,
  input  logic         rotate_L_valid,
  input  logic         move_R_valid,
  input  logic         move_L_valid,
  input  logic         soft_drop_valid,
  input  logic [4:0]   rotate_R_row_kick,
  input  logic [4:0]   rotate_R_col_kick,
  input  logic [4:0]   rotate_L_row_kick,
  input  logic [4:0]   rotate_L_col_kick,
  output tile_type_t   falling_type,
  output logic [4:0]   falling_row,
  output logic [4:0]   falling_col,
  output orientation_t falling_orientation,
  output logic         falling_active,
  output logic         lock_pulse,
  output logic [1:0]   state_dbg
);

  fc_state_t    state_q, state_d;
  logic [4:0]   row_q, row_d, col_q, col_d;
  orientation_t orient_q, orient_d;
  tile_type_t   type_q, type_d;

  logic spawn_accept;
  logic applied;   // any action changed the piece this cycle
  logic moved;     // the applied action was a move or rotate
  logic lock_expired;
  logic lock_reset_avail;

  // Candidate origins for the validity checker, all from registered state.
  assign rotate_R_row          = row_q;
  assign rotate_R_col          = col_q;
  assign rotate_R_orientation  = orient_cw(orient_q);
  assign rotate_L_row          = row_q;
  assign rotate_L_col          = col_q;
  assign rotate_L_orientation  = orient_ccw(orient_q);
  assign move_R_row            = row_q;
  assign move_R_col            = col_q + 5'd1;
  assign move_R_orientation    = orient_q;
  assign move_L_row            = row_q;
  assign move_L_col            = col_q - 5'd1;  // 0 wraps to 31; the checker rejects it
  assign move_L_orientation    = orient_q;
  assign soft_drop_row         = row_q + 5'd1;
  assign soft_drop_col         = col_q;
  assign soft_drop_orientation = orient_q;

  assign falling_type        = type_q;
  assign falling_row         = row_q;
  assign falling_col         = col_q;
  assign falling_orientation = orient_q;
  assign falling_active      = (state_q == FC_FALLING) || (state_q == FC_LOCKING);
  assign spawn_ready         = (state_q == FC_IDLE);
  assign lock_pulse          = (state_q == FC_LOCKED);
  assign state_dbg           = state_q;

  falling_piece_controller_lock_delay_timer #(
    .LOCK_DELAY_CYCLES(LOCK_DELAY_CYCLES),
    .MAX_LOCK_RESETS  (MAX_LOCK_RESETS)
  ) u_lock_timer (
    .clk        (clk),
    .rst_l      (rst_l),
    .clear_all  (spawn_accept),
    .restart    (state_q != FC_LOCKING),
    .count_en   (state_q == FC_LOCKING),
    .kick       ((state_q == FC_LOCKING) && moved),
    .expired    (lock_expired),
    .reset_avail(lock_reset_avail)
  );

  // Piece state and FSM register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= FC_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      orient_q <= ORIENTATION_0;
      type_q   <= BLANK;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      orient_q <= orient_d;
      type_q   <= type_d;
    end
  end

  // Action priority, piece update and next state.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    orient_d     = orient_q;
    type_d       = type_q;
    spawn_accept = 1'b0;
    applied      = 1'b0;
    moved        = 1'b0;
    case (state_q)
      FC_IDLE: begin
        if (spawn_valid) begin
          spawn_accept = 1'b1;
          row_d        = SPAWN_ROW;
          col_d        = SPAWN_COL;
          orient_d     = ORIENTATION_0;
          type_d       = spawn_type;
          state_d      = FC_FALLING;
        end
      end
      FC_FALLING, FC_LOCKING: begin
        if (in_hard_drop) begin
          row_d   = hard_drop_row;
          applied = 1'b1;
        end else if (in_rotate_R && rotate_R_valid) begin
          row_d    = rotate_R_row_kick;
          col_d    = rotate_R_col_kick;
          orient_d = orient_cw(orient_q);
          applied  = 1'b1;
          moved    = 1'b1;
        end else if (in_rotate_L && rotate_L_valid) begin
          row_d    = rotate_L_row_kick;
          col_d    = rotate_L_col_kick;
          orient_d = orient_ccw(orient_q);
          applied  = 1'b1;
          moved    = 1'b1;
        end else if (in_move_R && move_R_valid) begin
          col_d   = col_q + 5'd1;
          applied = 1'b1;
          moved   = 1'b1;
        end else if (in_move_L && move_L_valid) begin
          col_d   = col_q - 5'd1;
          applied = 1'b1;
          moved   = 1'b1;
        end else if ((in_soft_drop || gravity_tick) && soft_drop_valid) begin
          row_d   = row_q + 5'd1;
          applied = 1'b1;
        end

        if (in_hard_drop) begin
          state_d = FC_LOCKED;
        end else if (state_q == FC_FALLING) begin
          if (!applied && !soft_drop_valid) state_d = FC_LOCKING;
        end else begin
          if (soft_drop_valid)                  state_d = FC_FALLING;
          else if (!applied && lock_expired)    state_d = FC_LOCKED;
        end
      end
      default: begin
        state_d = FC_IDLE;
      end
    endcase
  end

  // lock_reset_avail is consumed inside the timer; exposed here only for completeness of the hookup.
  logic unused_ok;
  assign unused_ok = lock_reset_avail;

endmodule

// File: tb/tb_falling_piece_controller.sv
// Directed bench for falling_piece_controller (LOCK_DELAY_CYCLES=8, MAX_LOCK_RESETS=1).
module tb_falling_piece_controller;
  import falling_piece_controller_pkg::*;

  logic clk = 1'b0;
  logic rst_l;
  logic spawn_valid, spawn_ready, gravity_tick;
  tile_type_t spawn_type, falling_type;
  logic in_rotate_R, in_rotate_L, in_move_R, in_move_L, in_soft_drop, in_hard_drop;
  logic [4:0] hard_drop_row;
  logic [4:0] rotate_R_row, rotate_R_col, rotate_L_row, rotate_L_col;
  logic [4:0] move_R_row, move_R_col, move_L_row, move_L_col, soft_drop_row, soft_drop_col;
  orientation_t rotate_R_orientation, rotate_L_orientation, move_R_orientation;
  orientation_t move_L_orientation, soft_drop_orientation, falling_orientation;
  logic rotate_R_valid, rotate_L_valid, move_R_valid, move_L_valid, soft_drop_valid;
  logic [4:0] rotate_R_row_kick, rotate_R_col_kick, rotate_L_row_kick, rotate_L_col_kick;
  logic [4:0] falling_row, falling_col;
  logic falling_active, lock_pulse;
  logic [1:0] state_dbg;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [19:0] exp_q[$];

  typedef struct {
    logic         spawn;
    tile_type_t   stype;
    logic [5:0]   act;   // hard, rot_R, rot_L, move_R, move_L, soft
    logic         grav;
    logic [4:0]   vld;   // rot_R, rot_L, move_R, move_L, soft
    logic [4:0]   kr_row, kr_col, kl_row, kl_col;
    logic [4:0]   e_row, e_col;
    orientation_t e_or;
    tile_type_t   e_type;
    fc_state_t    e_state;
  } vec_t;

  localparam int NV = 15;
  vec_t vt[NV];

  falling_piece_controller #(
    .LOCK_DELAY_CYCLES(8),
    .MAX_LOCK_RESETS  (1)
  ) dut (
    .clk(clk), .rst_l(rst_l),
    .spawn_valid(spawn_valid), .spawn_type(spawn_type), .spawn_ready(spawn_ready),
    .gravity_tick(gravity_tick),
    .in_rotate_R(in_rotate_R), .in_rotate_L(in_rotate_L), .in_move_R(in_move_R),
    .in_move_L(in_move_L), .in_soft_drop(in_soft_drop), .in_hard_drop(in_hard_drop),
    .hard_drop_row(hard_drop_row),
    .rotate_R_row(rotate_R_row), .rotate_R_col(rotate_R_col),
    .rotate_L_row(rotate_L_row), .rotate_L_col(rotate_L_col),
    .move_R_row(move_R_row), .move_R_col(move_R_col),
    .move_L_row(move_L_row), .move_L_col(move_L_col),
    .soft_drop_row(soft_drop_row), .soft_drop_col(soft_drop_col),
    .rotate_R_orientation(rotate_R_orientation), .rotate_L_orientation(rotate_L_orientation),
    .move_R_orientation(move_R_orientation), .move_L_orientation(move_L_orientation),
    .soft_drop_orientation(soft_drop_orientation),
    .rotate_R_valid(rotate_R_valid), .rotate_L_valid(rotate_L_valid),
    .move_R_valid(move_R_valid), .move_L_valid(move_L_valid), .soft_drop_valid(soft_drop_valid),
    .rotate_R_row_kick(rotate_R_row_kick), .rotate_R_col_kick(rotate_R_col_kick),
    .rotate_L_row_kick(rotate_L_row_kick), .rotate_L_col_kick(rotate_L_col_kick),
    .falling_type(falling_type), .falling_row(falling_row), .falling_col(falling_col),
    .falling_orientation(falling_orientation), .falling_active(falling_active),
    .lock_pulse(lock_pulse), .state_dbg(state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    spawn_valid = 1'b0; gravity_tick = 1'b0;
    in_rotate_R = 1'b0; in_rotate_L = 1'b0; in_move_R = 1'b0;
    in_move_L = 1'b0; in_soft_drop = 1'b0; in_hard_drop = 1'b0;
    rotate_R_valid = 1'b1; rotate_L_valid = 1'b1; move_R_valid = 1'b1;
    move_L_valid = 1'b1; soft_drop_valid = 1'b1;
  endtask

  // Expected-output word: position, type, state and the three state-derived flags.
  function automatic logic [19:0] pack_exp(input logic [4:0] r, input logic [4:0] c,
                                           input orientation_t o, input tile_type_t t,
                                           input fc_state_t s);
    logic act_e, rdy_e, lck_e;
    act_e = (s == FC_FALLING) || (s == FC_LOCKING);
    rdy_e = (s == FC_IDLE);
    lck_e = (s == FC_LOCKED);
    return {r, c, o, t, s, act_e, rdy_e, lck_e};
  endfunction

  function automatic logic [19:0] pack_dut();
    return {falling_row, falling_col, falling_orientation, falling_type, state_dbg,
            falling_active, spawn_ready, lock_pulse};
  endfunction

  // Expect lock_pulse low for n-1 cycles and high on the n-th.
  task automatic wait_lock(input string name, input int n);
    for (int i = 1; i <= n; i++) begin
      step();
      check(name, {31'd0, lock_pulse}, {31'd0, (i == n)});
    end
  endtask

  task automatic spawn_piece(input tile_type_t t);
    spawn_type  = t;
    spawn_valid = 1'b1;
    step();
    spawn_valid = 1'b0;
    check("spawn_state", {30'd0, state_dbg}, {30'd0, FC_FALLING});
    check("spawn_type", {29'd0, falling_type}, {29'd0, t});
  endtask

  initial begin
    tile_type_t rt;
    logic seen;
    //                 spawn stype   act        grav vld       krr   krc   klr   klc   row   col   or             type    state
    vt[0]  = '{1'b1, TILE_T, 6'b000000, 1'b0, 5'b11111, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd4, ORIENTATION_0, TILE_T, FC_FALLING};
    vt[1]  = '{1'b1, TILE_I, 6'b000000, 1'b0, 5'b11111, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd4, ORIENTATION_0, TILE_T, FC_FALLING};
    vt[2]  = '{1'b0, BLANK,  6'b010000, 1'b0, 5'b11111, 5'd2, 5'd3, 5'd0, 5'd0, 5'd2, 5'd3, ORIENTATION_R, TILE_T, FC_FALLING};
    vt[3]  = '{1'b0, BLANK,  6'b010000, 1'b0, 5'b01111, 5'd9, 5'd9, 5'd0, 5'd0, 5'd2, 5'd3, ORIENTATION_R, TILE_T, FC_FALLING};
    vt[4]  = '{1'b0, BLANK,  6'b000110, 1'b0, 5'b11111, 5'd0, 5'd0, 5'd0, 5'd0, 5'd2, 5'd4, ORIENTATION_R, TILE_T, FC_FALLING};
    vt[5]  = '{1'b0, BLANK,  6'b000010, 1'b0, 5'b11111, 5'd0, 5'd0, 5'd0, 5'd0, 5'd2, 5'd3, ORIENTATION_R, TILE_T, FC_FALLING};
    vt[6]  = '{1'b0, BLANK,  6'b000001, 1'b0, 5'b11111, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd3, ORIENTATION_R, TILE_T, FC_FALLING};
    vt[7]  = '{1'b0, BLANK,  6'b000000, 1'b1, 5'b11111, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd3, ORIENTATION_R, TILE_T, FC_FALLING};
    vt[8]  = '{1'b0, BLANK,  6'b000001, 1'b1, 5'b11111, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd3, ORIENTATION_R, TILE_T, FC_FALLING};
    vt[9]  = '{1'b0, BLANK,  6'b001000, 1'b0, 5'b11111, 5'd0, 5'd0, 5'd6, 5'd2, 5'd6, 5'd2, ORIENTATION_0, TILE_T, FC_FALLING};
    vt[10] = '{1'b0, BLANK,  6'b011000, 1'b0, 5'b11111, 5'd7, 5'd5, 5'd9, 5'd9, 5'd7, 5'd5, ORIENTATION_R, TILE_T, FC_FALLING};
    vt[11] = '{1'b0, BLANK,  6'b010100, 1'b0, 5'b01111, 5'd1, 5'd1, 5'd0, 5'd0, 5'd7, 5'd6, ORIENTATION_R, TILE_T, FC_FALLING};
    vt[12] = '{1'b0, BLANK,  6'b011010, 1'b0, 5'b00111, 5'd1, 5'd1, 5'd1, 5'd1, 5'd7, 5'd5, ORIENTATION_R, TILE_T, FC_FALLING};
    vt[13] = '{1'b0, BLANK,  6'b000001, 1'b1, 5'b11110, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd5, ORIENTATION_R, TILE_T, FC_LOCKING};
    vt[14] = '{1'b0, BLANK,  6'b000000, 1'b0, 5'b11111, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd5, ORIENTATION_R, TILE_T, FC_FALLING};

    // Reset.
    rst_l = 1'b0;
    idle_inputs();
    spawn_type = BLANK; hard_drop_row = 5'd0;
    rotate_R_row_kick = 5'd0; rotate_R_col_kick = 5'd0;
    rotate_L_row_kick = 5'd0; rotate_L_col_kick = 5'd0;
    repeat (2) @(posedge clk);
    #1 rst_l = 1'b1;
    #1 check("reset_state", {12'd0, pack_dut()},
             {12'd0, pack_exp(5'd0, 5'd0, ORIENTATION_0, BLANK, FC_IDLE)});

    // Table: spawn, priority and drop behaviour in FALLING.
    for (int i = 0; i < NV; i++) begin
      spawn_valid = vt[i].spawn; spawn_type = vt[i].stype;
      {in_hard_drop, in_rotate_R, in_rotate_L, in_move_R, in_move_L, in_soft_drop} = vt[i].act;
      gravity_tick = vt[i].grav;
      {rotate_R_valid, rotate_L_valid, move_R_valid, move_L_valid, soft_drop_valid} = vt[i].vld;
      rotate_R_row_kick = vt[i].kr_row; rotate_R_col_kick = vt[i].kr_col;
      rotate_L_row_kick = vt[i].kl_row; rotate_L_col_kick = vt[i].kl_col;
      exp_q.push_back(pack_exp(vt[i].e_row, vt[i].e_col, vt[i].e_or, vt[i].e_type, vt[i].e_state));
      step();
      check($sformatf("vec%0d", i), {12'd0, pack_dut()}, {12'd0, exp_q.pop_front()});
    end
    idle_inputs();

    // Resting with gravity held: lock 8 cycles after entering LOCKING, position held.
    soft_drop_valid = 1'b0; gravity_tick = 1'b1;
    step();
    check("rest_enter", {30'd0, state_dbg}, {30'd0, FC_LOCKING});
    wait_lock("rest_lock", 8);
    check("rest_locked_pos", {12'd0, pack_dut()},
          {12'd0, pack_exp(5'd7, 5'd5, ORIENTATION_R, TILE_T, FC_LOCKED)});
    idle_inputs();
    step();
    check("rest_idle", {30'd0, state_dbg}, {30'd0, FC_IDLE});

    // One lock restart allowed; the second move does not restart.
    rt = tile_type_t'($urandom_range(1, 7));
    spawn_piece(rt);
    soft_drop_valid = 1'b0;
    step();
    check("kick_enter", {30'd0, state_dbg}, {30'd0, FC_LOCKING});
    repeat (5) step();
    in_move_R = 1'b1; step(); in_move_R = 1'b0;
    check("kick_move1_col", {27'd0, falling_col}, {27'd0, 5'd5});
    repeat (2) step();
    check("kick_restarted", {30'd0, state_dbg}, {30'd0, FC_LOCKING});
    step();
    in_move_R = 1'b1; step(); in_move_R = 1'b0;
    check("kick_move2_col", {27'd0, falling_col}, {27'd0, 5'd6});
    wait_lock("kick_lock", 4);
    idle_inputs();
    step();

    // Hard drop beats every other action; spawn offered during LOCKED is refused.
    rt = tile_type_t'($urandom_range(1, 7));
    spawn_piece(rt);
    in_hard_drop = 1'b1; in_rotate_R = 1'b1; in_move_R = 1'b1; hard_drop_row = 5'd19;
    step();
    idle_inputs();
    check("hard_drop", {12'd0, pack_dut()},
          {12'd0, pack_exp(5'd19, 5'd4, ORIENTATION_0, rt, FC_LOCKED)});
    spawn_valid = 1'b1; spawn_type = TILE_O;
    step();
    check("locked_no_spawn", {30'd0, state_dbg}, {30'd0, FC_IDLE});
    check("after_lock_pulse", {31'd0, lock_pulse}, 32'd0);
    step();
    spawn_valid = 1'b0;
    check("idle_spawn", {12'd0, pack_dut()},
          {12'd0, pack_exp(5'd1, 5'd4, ORIENTATION_0, TILE_O, FC_FALLING)});

    // Leaving LOCKING on soft_drop_valid clears the counter.
    soft_drop_valid = 1'b0;
    step();
    repeat (4) step();
    soft_drop_valid = 1'b1;
    step();
    check("unrest", {30'd0, state_dbg}, {30'd0, FC_FALLING});
    soft_drop_valid = 1'b0;
    step();
    check("rerest", {30'd0, state_dbg}, {30'd0, FC_LOCKING});
    wait_lock("rerest_lock", 8);
    idle_inputs();
    step();

    // Reset while LOCKING discards the piece without a lock pulse.
    spawn_piece(TILE_S);
    soft_drop_valid = 1'b0;
    repeat (4) step();
    rst_l = 1'b0;
    #1 check("mid_reset", {12'd0, pack_dut()},
             {12'd0, pack_exp(5'd0, 5'd0, ORIENTATION_0, BLANK, FC_IDLE)});
    @(posedge clk);
    #1 rst_l = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (lock_pulse) seen = 1'b1;
    end
    check("no_pulse_after_reset", {31'd0, seen}, 32'd0);
    check("idle_after_reset", {30'd0, state_dbg}, {30'd0, FC_IDLE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
